// File: rtl/i2c_init_seq.sv
// i2c_init_seq: issues the seven-word WM8731 register init sequence through a
// single-transaction I2C write master, one word per start pulse.
// Optional feature macro I2C_INIT_TIMEOUT_EN: per-word timeout with bounded
// re-issue of the same word; without it WAIT holds indefinitely and o_error is 0.

module i2c_init_seq #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_i2c_fin,
    output logic        o_i2c_start,
    output logic [6:0]  o_i2c_addr,
    output logic        o_i2c_rw,
    output logic [15:0] o_i2c_reg_data,
    output logic [2:0]  o_index,
    output logic        o_busy,
    output logic        o_finished,
    output logic        o_error
);

    typedef enum logic [2:0] {StIdle, StLoad, StPulse, StWait, StGap, StDone} state_e;

    // GAP lasts GAP_CYCLES+1 cycles so that pulse-to-pulse spacing after a
    // detected fin edge is 3+GAP_CYCLES (GAP, LOAD, PULSE).
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES);

    state_e          state_q, state_d;
    logic [2:0]      index_q, index_d;
    logic [15:0]     data_q, data_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            fin_q;
    logic            fin_rise;

`ifdef I2C_INIT_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    logic [ToW-1:0]    to_q, to_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              error_q, error_d;
`else
    logic [63:0] unused_cfg;
    assign unused_cfg = {TIMEOUT_CYCLES, MAX_RETRY};
`endif

    // WM8731 init table: reset, analogue path, digital path, power down,
    // interface format, sampling, active.
    function automatic logic [15:0] word_at(input logic [2:0] idx);
        case (idx)
            3'd0:    word_at = 16'h1E00;
            3'd1:    word_at = 16'h0815;
            3'd2:    word_at = 16'h0A00;
            3'd3:    word_at = 16'h0C00;
            3'd4:    word_at = 16'h0E42;
            3'd5:    word_at = 16'h1019;
            3'd6:    word_at = 16'h1201;
            default: word_at = 16'h0000;
        endcase
    endfunction

    // A fin level already high on WAIT entry has fin_q=1 and never counts.
    assign fin_rise = i_i2c_fin & ~fin_q;

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            index_q <= 3'd0;
            data_q  <= 16'h0000;
            gap_q   <= '0;
            fin_q   <= 1'b0;
`ifdef I2C_INIT_TIMEOUT_EN
            to_q    <= '0;
            retry_q <= '0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            fin_q   <= i_i2c_fin;
`ifdef I2C_INIT_TIMEOUT_EN
            to_q    <= to_d;
            retry_q <= retry_d;
            error_q <= error_d;
`endif
        end
    end

    // Next-state logic; the data word only changes on entry to LOAD.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        data_d  = data_q;
        gap_d   = gap_q;
`ifdef I2C_INIT_TIMEOUT_EN
        to_d    = to_q;
        retry_d = retry_q;
        error_d = error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d = StLoad;
                    index_d = 3'd0;
                    data_d  = word_at(3'd0);
`ifdef I2C_INIT_TIMEOUT_EN
                    error_d = 1'b0;
                    retry_d = '0;
`endif
                end
            end
            StLoad: state_d = StPulse;
            StPulse: begin
                state_d = StWait;
`ifdef I2C_INIT_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            StWait: begin
                if (fin_rise) begin
`ifdef I2C_INIT_TIMEOUT_EN
                    retry_d = '0;
`endif
                    if (index_q == 3'd6) begin
                        state_d = StDone;
                    end else begin
                        state_d = StGap;
                        gap_d   = '0;
                    end
                end
`ifdef I2C_INIT_TIMEOUT_EN
                else if (to_q == ToLast) begin
                    if (retry_q == RetryMax) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = StPulse;
                    end
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StLoad;
                    index_d = index_q + 3'd1;
                    data_d  = word_at(index_q + 3'd1);
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign o_i2c_start    = (state_q == StPulse);
    assign o_finished     = (state_q == StDone);
    assign o_busy         = (state_q == StLoad) || (state_q == StPulse) ||
                            (state_q == StWait) || (state_q == StGap);
    assign o_i2c_addr     = 7'b0011010;
    assign o_i2c_rw       = 1'b0;
    assign o_i2c_reg_data = data_q;
    assign o_index        = index_q;
`ifdef I2C_INIT_TIMEOUT_EN
    assign o_error        = error_q;
`else
    assign o_error        = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq with a simple I2C master model that raises
// fin 100 cycles after each start pulse. The timeout test runs only when
// I2C_INIT_TIMEOUT_EN is defined.

module tb_i2c_init_seq;

    localparam logic [15:0] EXP [7] = '{16'h1E00, 16'h0815, 16'h0A00, 16'h0C00,
                                        16'h0E42, 16'h1019, 16'h1201};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        fin_force = 1'b0;
    logic        fin_model = 1'b0;
    logic        i_i2c_fin;
    logic        o_i2c_start, o_i2c_rw, o_busy, o_finished, o_error;
    logic [6:0]  o_i2c_addr;
    logic [15:0] o_i2c_reg_data;
    logic [2:0]  o_index;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fin_cnt = 0;
    bit model_on = 1'b0;
    bit last_fin_err, last_fin_busy;

    logic [15:0] st_data[$];
    int          st_cyc[$];
    logic [2:0]  st_idx[$];
    int          fe_cyc[$];
    logic [15:0] fe_data[$];

    assign i_i2c_fin = fin_force | fin_model;

    i2c_init_seq #(
        .GAP_CYCLES    (16),
        .TIMEOUT_CYCLES(200),
        .MAX_RETRY     (3)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_i2c_fin     (i_i2c_fin),
        .o_i2c_start   (o_i2c_start),
        .o_i2c_addr    (o_i2c_addr),
        .o_i2c_rw      (o_i2c_rw),
        .o_i2c_reg_data(o_i2c_reg_data),
        .o_index       (o_index),
        .o_busy        (o_busy),
        .o_finished    (o_finished),
        .o_error       (o_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every start pulse and finish pulse.
    always @(negedge clk) begin
        if (o_i2c_start) begin
            st_data.push_back(o_i2c_reg_data);
            st_cyc.push_back(cyc);
            st_idx.push_back(o_index);
        end
        if (o_finished) begin
            fin_cnt       <= fin_cnt + 1;
            last_fin_err  <= o_error;
            last_fin_busy <= o_busy;
        end
    end

    // I2C master model: fin high 100 cycles after a start, held for 5 cycles.
    initial begin
        int cd;
        int hold;
        cd = 0;
        hold = 0;
        forever begin
            @(negedge clk);
            if (o_i2c_start && model_on) cd = 100;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cd = 0;
                hold = 0;
                fin_model = 1'b0;
            end else if (cd > 0) begin
                cd = cd - 1;
                if (cd == 0) begin
                    fin_model = 1'b1;
                    hold = 5;
                    fe_cyc.push_back(cyc);
                    fe_data.push_back(o_i2c_reg_data);
                end
            end else if (hold > 0) begin
                hold = hold - 1;
                if (hold == 0) fin_model = 1'b0;
            end
        end
    end

    task automatic clear_log();
        st_data.delete();
        st_cyc.delete();
        st_idx.delete();
        fe_cyc.delete();
        fe_data.delete();
    endtask

    task automatic pulse_start(output int c);
        @(posedge clk);
        #1;
        i_start = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (st_data.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done_cycle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (o_finished) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({o_i2c_start, o_busy, o_finished, o_error} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000",
                     {o_i2c_start, o_busy, o_finished, o_error});
        end
        total++;
        if (o_index !== 3'd0 || o_i2c_reg_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_idx_data: got %0d/%h want 0/0000", o_index, o_i2c_reg_data);
        end
        total++;
        if (o_i2c_addr !== 7'h1A || o_i2c_rw !== 1'b0) begin
            bad++;
            $display("FAIL reset_addr_rw: got %h/%b want 1a/0", o_i2c_addr, o_i2c_rw);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        int c;
        int base;
        bit ok;
        clear_log();
        model_on = 1'b1;
        base = fin_cnt;
        pulse_start(c);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b1 || o_index !== 3'd0 || o_i2c_reg_data !== 16'h1E00) begin
            bad++;
            $display("FAIL load_state: got busy=%b idx=%0d data=%h want 1/0/1e00",
                     o_busy, o_index, o_i2c_reg_data);
        end
        wait_done_cycle(2000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL seq_timeout: got no finish want finish within 2000 cycles");
        end
        @(negedge clk);
        total++;
        if (st_data.size() != 7 || fin_cnt != base + 1) begin
            bad++;
            $display("FAIL seq_counts: got starts=%0d fins=%0d want 7/1",
                     st_data.size(), fin_cnt - base);
        end
        for (int i = 0; i < 7 && i < st_data.size(); i++) begin
            total++;
            if (st_data[i] !== EXP[i] || st_idx[i] !== 3'(i)) begin
                bad++;
                $display("FAIL seq_word%0d: got %h idx %0d want %h idx %0d",
                         i, st_data[i], st_idx[i], EXP[i], i);
            end
        end
        total++;
        if (st_data.size() > 0 && st_cyc[0] != c + 2) begin
            bad++;
            $display("FAIL first_latency: got %0d want %0d", st_cyc[0] - c, 2);
        end
        for (int i = 0; i < 6 && i + 1 < st_cyc.size() && i < fe_cyc.size(); i++) begin
            total++;
            if (st_cyc[i + 1] - fe_cyc[i] != 19 || fe_data[i] !== EXP[i]) begin
                bad++;
                $display("FAIL gap_latency%0d: got %0d data %h want 19 data %h",
                         i, st_cyc[i + 1] - fe_cyc[i], fe_data[i], EXP[i]);
            end
        end
        total++;
        if (last_fin_err !== 1'b0 || last_fin_busy !== 1'b0) begin
            bad++;
            $display("FAIL done_flags: got err=%b busy=%b want 0/0", last_fin_err, last_fin_busy);
        end
        model_on = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_start_ignored();
        int c;
        int base;
        bit ok;
        clear_log();
        model_on = 1'b1;
        base = fin_cnt;
        pulse_start(c);
        wait_starts(4, 1000, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ign_reach_word3: got %0d starts want 4", st_data.size());
        end
        pulse_start(c);
        wait_done_cycle(2000, ok);
        // Start requested in the DONE cycle must also be dropped.
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++;
        if (!ok || st_data.size() != 7 || fin_cnt != base + 1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_restart: got starts=%0d fins=%0d busy=%b want 7/1/0",
                     st_data.size(), fin_cnt - base, o_busy);
        end
        model_on = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        int c;
        int base;
        bit ok;
        clear_log();
        model_on = 1'b1;
        pulse_start(c);
        wait_starts(5, 1000, ok);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (!ok || {o_busy, o_i2c_start, o_finished, o_error} !== 4'b0000 ||
            o_index !== 3'd0 || o_i2c_reg_data !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset: got busy=%b idx=%0d data=%h want 0/0/0000",
                     o_busy, o_index, o_i2c_reg_data);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_log();
        base = fin_cnt;
        pulse_start(c);
        wait_starts(1, 10, ok);
        total++;
        if (!ok || st_data[0] !== 16'h1E00 || st_idx[0] !== 3'd0) begin
            bad++;
            $display("FAIL restart_word0: got %h want 1e00", ok ? st_data[0] : 16'hxxxx);
        end
        wait_done_cycle(2000, ok);
        @(negedge clk);
        total++;
        if (!ok || st_data.size() != 7 || fin_cnt != base + 1) begin
            bad++;
            $display("FAIL restart_full: got starts=%0d want 7", st_data.size());
        end
        model_on = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_fin_held();
        int c;
        int e;
        int base;
        bit ok;
        clear_log();
        model_on = 1'b0;
        base = fin_cnt;
        fin_force = 1'b1;
        repeat (3) @(posedge clk);
        pulse_start(c);
        repeat (150) @(posedge clk);
        #1;
        total++;
        if (st_data.size() != 1 || o_busy !== 1'b1 || fin_cnt != base || o_index !== 3'd0) begin
            bad++;
            $display("FAIL fin_held: got starts=%0d busy=%b idx=%0d want 1/1/0",
                     st_data.size(), o_busy, o_index);
        end
        fin_force = 1'b0;
        @(posedge clk);
        #1;
        fin_force = 1'b1;
        e = cyc;
        wait_starts(2, 50, ok);
        total++;
        if (!ok || st_cyc[1] != e + 19 || st_data[1] !== 16'h0815) begin
            bad++;
            $display("FAIL fin_fresh_edge: got lat=%0d data=%h want 19/0815",
                     ok ? st_cyc[1] - e : -1, ok ? st_data[1] : 16'hxxxx);
        end
        fin_force = 1'b0;
        do_reset();
    endtask

`ifdef I2C_INIT_TIMEOUT_EN
    task automatic test_timeout();
        int c;
        bit ok;
        clear_log();
        model_on = 1'b0;
        fin_force = 1'b0;
        pulse_start(c);
        wait_done_cycle(3000, ok);
        total++;
        if (!ok || o_error !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL to_abort: got done=%b err=%b busy=%b want 1/1/0", ok, o_error, o_busy);
        end
        total++;
        if (st_data.size() != 4) begin
            bad++;
            $display("FAIL to_issues: got %0d want 4", st_data.size());
        end
        for (int i = 0; i < st_data.size(); i++) begin
            total++;
            if (st_data[i] !== 16'h1E00) begin
                bad++;
                $display("FAIL to_word%0d: got %h want 1e00", i, st_data[i]);
            end
        end
        total++;
        if (st_cyc.size() > 1 && st_cyc[1] - st_cyc[0] != 201) begin
            bad++;
            $display("FAIL to_spacing: got %0d want 201", st_cyc[1] - st_cyc[0]);
        end
        repeat (5) @(negedge clk);
        total++;
        if (o_error !== 1'b1) begin
            bad++;
            $display("FAIL to_sticky: got %b want 1", o_error);
        end
        pulse_start(c);
        @(negedge clk);
        total++;
        if (o_error !== 1'b0) begin
            bad++;
            $display("FAIL to_clear: got %b want 0", o_error);
        end
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_start_ignored();
        test_reset_mid();
        test_fin_held();
`ifdef I2C_INIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
